// File: rtl/ghost_collision_ctrl.sv
// Per-frame player vs. ghost collision controller: serial bounding-box scan,
// lives / invulnerability / frightened bookkeeping and sticky game-over.
module ghost_collision_ctrl #(
  parameter int NUM_GHOSTS    = 4,
  parameter int COORD_W       = 10,
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int FRIGHT_FRAMES = 360,
  localparam int ID_W = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1,
  localparam int LW   = $clog2(LIVES + 1)
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          frame_tick,
  input  logic                          power_pellet,
  input  logic [COORD_W-1:0]            BallX,
  input  logic [COORD_W-1:0]            BallY,
  input  logic [COORD_W-1:0]            Ball_size,
  input  logic [NUM_GHOSTS*COORD_W-1:0] ghostX,
  input  logic [NUM_GHOSTS*COORD_W-1:0] ghostY,
  input  logic [NUM_GHOSTS*COORD_W-1:0] ghostS,
  input  logic [NUM_GHOSTS-1:0]         ghost_active,
  output logic [LW-1:0]                 lives,
  output logic                          over,
  output logic                          hit_pulse,
  output logic                          eaten_pulse,
  output logic [ID_W-1:0]               eaten_id,
  output logic                          frightened,
  output logic                          invuln,
  output logic                          busy
);

  localparam int FW = $clog2(FRIGHT_FRAMES + 1);
  localparam int IW = $clog2(INVULN_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, SCAN, RESOLVE, DEAD} state_e;

  state_e                  state_q, state_d;
  logic [ID_W-1:0]         idx_q, idx_d, hit_idx_q, hit_idx_d, eaten_id_q, eaten_id_d;
  logic                    hit_found_q, hit_found_d;
  logic                    fright_snap_q, fright_snap_d, invuln_snap_q, invuln_snap_d;
  logic [LW-1:0]           lives_q, lives_d;
  logic                    over_q, over_d, hit_pulse_q, hit_pulse_d;
  logic                    eaten_pulse_q, eaten_pulse_d, busy_q, busy_d;
  logic [FW-1:0]           fright_cnt_q, fright_cnt_d;
  logic [IW-1:0]           invuln_cnt_q, invuln_cnt_d;

  logic [COORD_W-1:0]            bx_q, by_q, bs_q;
  logic [NUM_GHOSTS*COORD_W-1:0] gx_q, gy_q, gs_q;
  logic [NUM_GHOSTS-1:0]         act_q;
  logic                          snap_en;

  logic [COORD_W-1:0] gx_cur, gy_cur, gs_cur;
  logic [COORD_W:0]   ball_x_hi, ball_y_hi, g_x_hi, g_y_hi;
  logic               cur_hit, found_final;
  logic [ID_W-1:0]    idx_final;

  // Overlap evaluated one bit wider than the coordinates so box ends never wrap.
  always_comb begin
    gx_cur    = gx_q[idx_q*COORD_W +: COORD_W];
    gy_cur    = gy_q[idx_q*COORD_W +: COORD_W];
    gs_cur    = gs_q[idx_q*COORD_W +: COORD_W];
    ball_x_hi = {1'b0, bx_q} + {1'b0, bs_q};
    ball_y_hi = {1'b0, by_q} + {1'b0, bs_q};
    g_x_hi    = {1'b0, gx_cur} + {1'b0, gs_cur};
    g_y_hi    = {1'b0, gy_cur} + {1'b0, gs_cur};
    cur_hit   = act_q[idx_q] &&
                ({1'b0, bx_q} <= g_x_hi) && ({1'b0, gx_cur} <= ball_x_hi) &&
                ({1'b0, by_q} <= g_y_hi) && ({1'b0, gy_cur} <= ball_y_hi);
    found_final = hit_found_q || cur_hit;
    idx_final   = hit_found_q ? hit_idx_q : idx_q;
  end

  assign snap_en = (state_q == IDLE) && frame_tick;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    state_d       = state_q;
    idx_d         = idx_q;
    hit_idx_d     = hit_idx_q;
    hit_found_d   = hit_found_q;
    fright_snap_d = fright_snap_q;
    invuln_snap_d = invuln_snap_q;
    lives_d       = lives_q;
    over_d        = over_q;
    eaten_id_d    = eaten_id_q;
    fright_cnt_d  = fright_cnt_q;
    invuln_cnt_d  = invuln_cnt_q;
    hit_pulse_d   = 1'b0;
    eaten_pulse_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          fright_snap_d = (fright_cnt_q != '0);
          invuln_snap_d = (invuln_cnt_q != '0);
          if (fright_cnt_q != '0) fright_cnt_d = fright_cnt_q - FW'(1);
          if (invuln_cnt_q != '0) invuln_cnt_d = invuln_cnt_q - IW'(1);
          idx_d       = '0;
          hit_found_d = 1'b0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        if (cur_hit && !hit_found_q) begin
          hit_found_d = 1'b1;
          hit_idx_d   = idx_q;
        end
        if (idx_q == ID_W'(NUM_GHOSTS - 1)) begin
          // Outcome is registered here so the pulses appear during RESOLVE.
          state_d = RESOLVE;
          if (found_final && fright_snap_q) begin
            eaten_pulse_d = 1'b1;
            eaten_id_d    = idx_final;
          end else if (found_final && !invuln_snap_q) begin
            hit_pulse_d  = 1'b1;
            lives_d      = lives_q - LW'(1);
            invuln_cnt_d = IW'(INVULN_FRAMES);
            if (lives_q == LW'(1)) over_d = 1'b1;
          end
        end else begin
          idx_d = idx_q + ID_W'(1);
        end
      end
      RESOLVE: state_d = over_q ? DEAD : IDLE;
      default: state_d = DEAD;
    endcase

    if (power_pellet && state_q != DEAD) fright_cnt_d = FW'(FRIGHT_FRAMES);

    busy_d = (state_d == SCAN) || (state_d == RESOLVE);
  end

  // NOTE: the snapshot registers carry no reset; they are only read after a frame_tick reloads them.
  always_ff @(posedge Clk) begin
    if (snap_en) begin
      bx_q  <= BallX;
      by_q  <= BallY;
      bs_q  <= Ball_size;
      gx_q  <= ghostX;
      gy_q  <= ghostY;
      gs_q  <= ghostS;
      act_q <= ghost_active;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      hit_idx_q     <= '0;
      hit_found_q   <= 1'b0;
      fright_snap_q <= 1'b0;
      invuln_snap_q <= 1'b0;
      lives_q       <= LW'(LIVES);
      over_q        <= 1'b0;
      eaten_id_q    <= '0;
      fright_cnt_q  <= '0;
      invuln_cnt_q  <= '0;
      hit_pulse_q   <= 1'b0;
      eaten_pulse_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      hit_idx_q     <= hit_idx_d;
      hit_found_q   <= hit_found_d;
      fright_snap_q <= fright_snap_d;
      invuln_snap_q <= invuln_snap_d;
      lives_q       <= lives_d;
      over_q        <= over_d;
      eaten_id_q    <= eaten_id_d;
      fright_cnt_q  <= fright_cnt_d;
      invuln_cnt_q  <= invuln_cnt_d;
      hit_pulse_q   <= hit_pulse_d;
      eaten_pulse_q <= eaten_pulse_d;
      busy_q        <= busy_d;
    end
  end

  assign lives       = lives_q;
  assign over        = over_q;
  assign hit_pulse   = hit_pulse_q;
  assign eaten_pulse = eaten_pulse_q;
  assign eaten_id    = eaten_id_q;
  assign frightened  = (fright_cnt_q != '0);
  assign invuln      = (invuln_cnt_q != '0);
  assign busy        = busy_q;

endmodule
